input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//   Parametrised N-channel conditioner for asynchronous board inputs (switches, push buttons).
//   Each channel gets:
//   - a SYNC_STAGES flip-flop synchroniser
//   - a debounce filter
//   - rise/fall one-cycle pulses
//   - a sticky event flag with per-channel clear
//   Sits between the board pins and the soc core. Replaces the per-bit synchroniser/debounce
//   generate loops with one block.
// PARAMETERS
//   N_CH           8           number of channels
//   SYNC_STAGES    2           synchroniser depth, >= 2
//   CLK_PERIOD_NS  20          clk period in ns
//   DEBOUNCE_NS    30_000_000  stable time needed before sig_o follows input
//   RESET_VAL      {N_CH{1'b0}} per-channel reset value of sync chain and sig_o
//   EVENT_EDGE     2'b01       sticky-event source: 01 rise, 10 fall, 11 either, 00 none
// PORTS
//   clk      in   1     system clock
//   reset    in   1     asynchronous, active-high reset
//   enable   in   1     debounce count qualifier; counters advance only when high
//   sig_i    in   N_CH  raw asynchronous inputs
//   clear    in   N_CH  synchronous per-channel clear of event_o
//   sig_o    out  N_CH  debounced level
//   rise_o   out  N_CH  one-cycle pulse, coincident with sig_o 0->1
//   fall_o   out  N_CH  one-cycle pulse, coincident with sig_o 1->0
//   event_o  out  N_CH  sticky flag, set per EVENT_EDGE, held until clear
// BEHAVIOUR
//   Derived constants:
//   - DB_CYC = DEBOUNCE_NS/CLK_PERIOD_NS. Forced to 1 if the division yields 0.
//   - CNT_W = $clog2(DB_CYC+1).
//   Reset (async assert, sync deassert at the consumer):
//   - sync chain and sig_o = RESET_VAL.
//   - counters = 0; rise_o, fall_o, event_o = 0.
//   Synchroniser:
//   - Plain shift chain, no enable. s = last stage.
//   Debounce counter, evaluated per channel on each clk edge:
//   - s == sig_o: cnt <= 0, regardless of enable.
//   - s != sig_o and enable=1 and cnt == DB_CYC-1: sig_o <= s, cnt <= 0.
//   - s != sig_o and enable=1, otherwise: cnt <= cnt+1.
//   - s != sig_o and enable=0: cnt holds.
//   - Net effect: sig_o flips only after DB_CYC consecutive enabled cycles of mismatch.
//     Any glitch back to sig_o restarts the count.
//   Latency:
//   - With enable held high, a clean sig_i step shows on sig_o exactly SYNC_STAGES+DB_CYC
//     clk edges later.
//   Edge pulses:
//   - rise_o/fall_o are registered and high for the single cycle in which sig_o shows its
//     new value.
//   - Never both high on one channel. Never high for 2 consecutive cycles.
//   Sticky event:
//   - event_o[k] sets on the cycle its selected pulse is high.
//   - clear[k]=1 clears it on the next edge.
//   - Simultaneous set and clear: set wins, event_o stays 1.
//   Channels are fully independent; no shared state beyond clk/reset/enable.
//   Reset mid-count: count discarded, outputs return to reset values immediately.
//   No pulse is generated by reset or its release. sig_o starts at RESET_VAL even if
//   sig_i differs; the normal debounce then applies.
//   Counter never exceeds DB_CYC-1, so there is no wrap-around.
// TESTING  (bench: CLK_PERIOD_NS=20, DEBOUNCE_NS=100 -> DB_CYC=5, N_CH=4, SYNC_STAGES=2)
//   1. Reset:
//      reset=1 with sig_i=4'hF, release ->
//      sig_o=0 until 7 edges later, then sig_o=4'hF; rise_o=4'hF for exactly 1 cycle.
//   2. Glitch rejection:
//      ch0 high 4 cycles then low, repeat 3x -> sig_o[0] stays 0, no rise_o/fall_o.
//   3. Enable gating:
//      enable toggles 1,0,1,0..., ch1 steps high -> sig_o[1] rises after 5 enabled cycles
//      (~11 edges after sync); rise_o[1] for 1 cycle.
//   4. Sticky/clear:
//      EVENT_EDGE=11, ch2 high then low -> event_o[2]=1 after the rise.
//      clear[2] in the same cycle as fall_o[2] -> event_o[2] remains 1.
//      clear[2] on a later cycle -> event_o[2]=0 next edge.
//   5. Reset mid-operation:
//      ch3 mismatched for 3 cycles, pulse reset 1 cycle -> all outputs 0 at once.
//      With sig_i still high, sig_o[3] rises 7 edges after release.
//   6. Independence:
//      ch0 and ch1 step opposite directions in the same cycle -> rise_o[0] and fall_o[1]
//      in the same cycle; ch2/ch3 quiet.

Source files
------------

// File: rtl/input_conditioner.sv
// N-channel conditioner for asynchronous board inputs: synchroniser, debounce filter,
// rise/fall pulses and a sticky event flag per channel.

module input_conditioner_ch #(
    parameter int          SYNC_STAGES = 2,
    parameter int          DB_CYC      = 1,
    parameter int          CNT_W       = 1,
    parameter logic        RESET_BIT   = 1'b0,
    parameter logic [1:0]  EVENT_EDGE  = 2'b01
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic sig_i,
    input  logic clear,
    output logic sig_o,
    output logic rise_o,
    output logic fall_o,
    output logic event_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   s;
    logic                   mismatch;
    logic                   flip;
    logic                   ev_set;

    assign s        = sync_q[SYNC_STAGES-1];
    assign mismatch = (s != sig_o);
    assign flip     = mismatch && enable && (cnt == CNT_W'(DB_CYC - 1));
    // The pulse registers feed the sticky flag, so a clear arriving during the
    // pulse cycle loses to the set.
    assign ev_set   = (EVENT_EDGE[0] & rise_o) | (EVENT_EDGE[1] & fall_o);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= {SYNC_STAGES{RESET_BIT}};
            cnt     <= '0;
            sig_o   <= RESET_BIT;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
            event_o <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
            rise_o  <= flip & s;
            fall_o  <= flip & ~s;
            event_o <= ev_set | (event_o & ~clear);
            if (!mismatch || flip) begin
                cnt <= '0;
            end else if (enable) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (flip) begin
                sig_o <= s;
            end
        end
    end
endmodule

module input_conditioner #(
    parameter int              N_CH          = 8,
    parameter int              SYNC_STAGES   = 2,
    parameter int              CLK_PERIOD_NS = 20,
    parameter int              DEBOUNCE_NS   = 30_000_000,
    parameter logic [N_CH-1:0] RESET_VAL     = '0,
    parameter logic [1:0]      EVENT_EDGE    = 2'b01
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [N_CH-1:0] sig_i,
    input  logic [N_CH-1:0] clear,
    output logic [N_CH-1:0] sig_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic [N_CH-1:0] event_o
);
    localparam int DB_RAW = DEBOUNCE_NS / CLK_PERIOD_NS;
    localparam int DB_CYC = (DB_RAW < 1) ? 1 : DB_RAW;
    localparam int CNT_W  = $clog2(DB_CYC + 1);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        input_conditioner_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYC      (DB_CYC),
            .CNT_W       (CNT_W),
            .RESET_BIT   (RESET_VAL[k]),
            .EVENT_EDGE  (EVENT_EDGE)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .enable  (enable),
            .sig_i   (sig_i[k]),
            .clear   (clear[k]),
            .sig_o   (sig_o[k]),
            .rise_o  (rise_o[k]),
            .fall_o  (fall_o[k]),
            .event_o (event_o[k])
        );
    end
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: 4 channels, DB_CYC=5, both edges raise events.

module tb_input_conditioner;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [3:0] sig_i = 4'h0;
    logic [3:0] clear = 4'h0;
    logic [3:0] sig_o, rise_o, fall_o, event_o;

    int checks = 0;
    int errors = 0;

    input_conditioner #(
        .N_CH          (4),
        .SYNC_STAGES   (2),
        .CLK_PERIOD_NS (20),
        .DEBOUNCE_NS   (100),
        .RESET_VAL     (4'h0),
        .EVENT_EDGE    (2'b11)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .sig_i   (sig_i),
        .clear   (clear),
        .sig_o   (sig_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o),
        .event_o (event_o)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] sig;
        logic [3:0] clr;
        logic       en;
        logic [3:0] es, er, ef, ee;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [3:0] s, input logic e, input logic [3:0] c,
                       input logic [3:0] es, input logic [3:0] er, input logic [3:0] ef,
                       input logic [3:0] ee, input int n);
        vec_t v;
        v.rst = r; v.sig = s; v.en = e; v.clr = c;
        v.es = es; v.er = er; v.ef = ef; v.ee = ee;
        repeat (n) vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset release with all inputs high: sig_o rises 7 edges later.
        add(1, 4'hF, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        add(0, 4'hF, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 6);
        add(0, 4'hF, 1, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 1);
        add(0, 4'hF, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1);
        add(0, 4'hF, 1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1);
        // Glitch rejection on ch0: 4-cycle highs never reach the 5-cycle threshold.
        add(1, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        add(0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2);
        for (int r = 0; r < 3; r++) begin
            add(0, 4'h1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4);
            add(0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4);
        end
        add(0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4);
        // Reset mid-count on ch3, then a full debounce after release.
        add(0, 4'h8, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5);
        add(1, 4'h8, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        add(0, 4'h8, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 6);
        add(0, 4'h8, 1, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 1);
        add(0, 4'h8, 1, 4'h0, 4'h8, 4'h0, 4'h0, 4'h8, 1);
        // Independence: ch1 up, then ch0 up and ch1 down in the same cycle.
        add(0, 4'hA, 1, 4'h0, 4'h8, 4'h0, 4'h0, 4'h8, 6);
        add(0, 4'hA, 1, 4'h0, 4'hA, 4'h2, 4'h0, 4'h8, 1);
        add(0, 4'hA, 1, 4'h0, 4'hA, 4'h0, 4'h0, 4'hA, 1);
        add(0, 4'h9, 1, 4'h0, 4'hA, 4'h0, 4'h0, 4'hA, 6);
        add(0, 4'h9, 1, 4'h0, 4'h9, 4'h1, 4'h2, 4'hA, 1);
        add(0, 4'h9, 1, 4'h0, 4'h9, 4'h0, 4'h0, 4'hB, 1);

        foreach (vq[i]) begin
            reset  = vq[i].rst;
            sig_i  = vq[i].sig;
            enable = vq[i].en;
            clear  = vq[i].clr;
            if (vq[i].rst) begin
                #1;
                chk($sformatf("v%0d async_rst", i), sig_o | rise_o | fall_o | event_o, 4'h0);
            end
            step();
            chk($sformatf("v%0d sig_o", i),   sig_o,   vq[i].es);
            chk($sformatf("v%0d rise_o", i),  rise_o,  vq[i].er);
            chk($sformatf("v%0d fall_o", i),  fall_o,  vq[i].ef);
            chk($sformatf("v%0d event_o", i), event_o, vq[i].ee);
        end
        reset = 1'b0;

        // Enable gating: alternating enable stretches the ch1 debounce to edge 11.
        sig_i = 4'hB;
        for (int k = 1; k <= 12; k++) begin
            enable = k[0];
            step();
            chk($sformatf("en%0d sig_o", k),  sig_o,  (k >= 11) ? 4'hB : 4'h9);
            chk($sformatf("en%0d rise_o", k), rise_o, (k == 11) ? 4'h2 : 4'h0);
        end
        enable = 1'b1;

        // Sticky event on ch2: set on rise, clear during fall pulse loses, later clear wins.
        clear = 4'hF;
        step();
        chk("stk clr_all", event_o, 4'h0);
        clear = 4'h0;
        sig_i = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("stk_r%0d sig_o", k),   sig_o,   (k >= 7) ? 4'hF : 4'hB);
            chk($sformatf("stk_r%0d rise_o", k),  rise_o,  (k == 7) ? 4'h4 : 4'h0);
            chk($sformatf("stk_r%0d event_o", k), event_o, (k == 8) ? 4'h4 : 4'h0);
        end
        sig_i = 4'hB;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("stk_f%0d sig_o", k),   sig_o,   (k >= 7) ? 4'hB : 4'hF);
            chk($sformatf("stk_f%0d fall_o", k),  fall_o,  (k == 7) ? 4'h4 : 4'h0);
            chk($sformatf("stk_f%0d event_o", k), event_o, 4'h4);
        end
        clear = 4'h4;
        step();
        chk("stk set_wins event_o", event_o, 4'h4);
        chk("stk set_wins fall_o", fall_o, 4'h0);
        clear = 4'h0;
        step();
        chk("stk hold event_o", event_o, 4'h4);
        clear = 4'h4;
        step();
        chk("stk cleared event_o", event_o, 4'h0);
        clear = 4'h0;
        step();
        chk("stk stays_clear event_o", event_o, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
